// File: rtl/ddr_test_pkg.sv
// ddr_test_pkg: shared types and constants for the DDR test monitor.
// Holds the FSM state encoding, the counter widths and a saturating
// increment helper used by the error counter.
package ddr_test_pkg;

  // Counter widths
  localparam int ERR_W  = 16;
  localparam int BEAT_W = 32;

  // State encoding, also visible on state_o
  localparam logic [1:0] ST_WAIT_CAL = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  typedef enum logic [1:0] {
    WAIT_CAL = ST_WAIT_CAL,
    SETTLE   = ST_SETTLE,
    RUN      = ST_RUN,
    FAULT    = ST_FAULT
  } state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single slow level signal.
// Both flops clear asynchronously on rst.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddr_test_monitor.sv
// ddr_test_monitor: watches the compare results of a DDR traffic checker.
// Waits for calibration, lets the interface settle, then counts compared
// beats and errors, raises a sticky any-error flag and a sticky burst flag
// when too many errors land inside one fixed window.
// Optional feature: define DDR_MON_ERR_LOG_EN to add first_err_beat, the
// beat_count value captured at the first error seen in RUN.
//
// Compare interface: cmp_valid marks one compared beat in this cycle;
// cmp_error is meaningful only while cmp_valid is high. There is no
// back-pressure, every valid beat is consumed in the cycle it appears.
module ddr_test_monitor
  import ddr_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned WINDOW_CYCLES = 4096,
  parameter int unsigned BURST_THRESH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_calib_complete,
  input  logic              cmp_valid,
  input  logic              cmp_error,
  input  logic              clear_i,
  output logic              init_calib_complete_d,
  output logic              error_int1,
  output logic              error_int2,
  output logic [ERR_W-1:0]  err_count,
  output logic [BEAT_W-1:0] beat_count,
  output logic [1:0]        state_o
`ifdef DDR_MON_ERR_LOG_EN
  ,
  output logic [BEAT_W-1:0] first_err_beat
`endif
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned WERR_W   = $clog2(BURST_THRESH + 1);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WERR_W-1:0]   THRESH      = WERR_W'(BURST_THRESH);

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [WIN_W-1:0]    win_q;
  logic [WERR_W-1:0]   werr_q, werr_sum;
  logic [BEAT_W-1:0]   beat_q;
  logic [ERR_W-1:0]    err_q;
  logic                int1_q, int2_q;
  logic                cal_d;
  logic                in_run, active, beat_hit, err_hit, burst_hit;

  sync_2ff u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (init_calib_complete),
    .q   (cal_d)
  );

  // Qualify compare events and form the per-window error sum.
  // win_q == 0 is the first cycle of a window: the running count restarts
  // there, so an error on that cycle belongs to the new window.
  always_comb begin
    in_run    = (state_q == RUN);
    active    = (state_q == RUN) || (state_q == FAULT);
    beat_hit  = active && cmp_valid && !clear_i;
    err_hit   = beat_hit && cmp_error;
    werr_sum  = ((win_q == '0) ? '0 : werr_q) + WERR_W'(in_run && err_hit);
    burst_hit = in_run && err_hit && (werr_sum == THRESH);
  end

  // FSM next state and settle down-counter; losing calibration wins over all
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      WAIT_CAL: begin
        if (cal_d) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d = RUN;
        else                settle_d = settle_q - 1'b1;
      end
      RUN: begin
        if (burst_hit) state_d = FAULT;
      end
      FAULT: begin
        if (clear_i) state_d = RUN;
      end
      default: state_d = WAIT_CAL;
    endcase
    if (!cal_d) state_d = WAIT_CAL;
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= WAIT_CAL;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Counters, sticky flags and burst window; clear drops any same-cycle error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= '0;
      err_q  <= '0;
      int1_q <= 1'b0;
      int2_q <= 1'b0;
      win_q  <= '0;
      werr_q <= '0;
    end else if (clear_i) begin
      beat_q <= '0;
      err_q  <= '0;
      int1_q <= 1'b0;
      int2_q <= 1'b0;
      win_q  <= '0;
      werr_q <= '0;
    end else begin
      if (beat_hit) beat_q <= beat_q + 1'b1;
      if (err_hit) begin
        err_q  <= sat_inc(err_q);
        int1_q <= 1'b1;
      end
      if (burst_hit) int2_q <= 1'b1;
      if (in_run) begin
        win_q  <= (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
        werr_q <= werr_sum;
      end else begin
        win_q  <= '0;
        werr_q <= '0;
      end
    end
  end

`ifdef DDR_MON_ERR_LOG_EN
  // Capture the beat index of the first error seen while running
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_err_beat <= '0;
    end else if (clear_i) begin
      first_err_beat <= '0;
    end else if (in_run && err_hit && !int1_q) begin
      first_err_beat <= beat_q;
    end
  end
`endif

  assign init_calib_complete_d = cal_d;
  assign error_int1            = int1_q;
  assign error_int2            = int2_q;
  assign err_count             = err_q;
  assign beat_count            = beat_q;
  assign state_o               = state_q;

endmodule

// File: tb/tb_ddr_test_monitor.sv
// tb_ddr_test_monitor: self-checking bench for ddr_test_monitor with a short
// settle time (16), a 64-cycle burst window and a burst threshold of 8.
module tb_ddr_test_monitor;

  localparam int SETTLE = 16;
  localparam int WIN    = 64;
  localparam int THRESH = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        init_calib_complete = 1'b0;
  logic        cmp_valid = 1'b0;
  logic        cmp_error = 1'b0;
  logic        clear_i = 1'b0;
  logic        init_calib_complete_d;
  logic        error_int1;
  logic        error_int2;
  logic [15:0] err_count;
  logic [31:0] beat_count;
  logic [1:0]  state_o;
`ifdef DDR_MON_ERR_LOG_EN
  logic [31:0] first_err_beat;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_beat_q[$];
  logic [15:0] exp_err_q[$];

  ddr_test_monitor #(
    .SETTLE_CYCLES (SETTLE),
    .WINDOW_CYCLES (WIN),
    .BURST_THRESH  (THRESH)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .init_calib_complete   (init_calib_complete),
    .cmp_valid             (cmp_valid),
    .cmp_error             (cmp_error),
    .clear_i               (clear_i),
    .init_calib_complete_d (init_calib_complete_d),
    .error_int1            (error_int1),
    .error_int2            (error_int2),
    .err_count             (err_count),
    .beat_count            (beat_count),
    .state_o               (state_o)
`ifdef DDR_MON_ERR_LOG_EN
    ,
    .first_err_beat        (first_err_beat)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmp_valid = 1'b0;
    cmp_error = 1'b0;
    clear_i   = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    init_calib_complete = 1'b0;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic bring_up();
    int n;
    apply_reset();
    init_calib_complete = 1'b1;
    n = 0;
    while (state_o !== 2'd2 && n < SETTLE + 10) begin
      tick();
      n++;
    end
    n_cmp++;
    if (state_o !== 2'd2) begin
      n_bad++;
      $display("FAIL bring_up: state_o=%0d required=2 after %0d cycles", state_o, n);
    end
  endtask

  task automatic drive_errors(input int n);
    for (int i = 0; i < n; i++) begin
      cmp_valid = 1'b1;
      cmp_error = 1'b1;
      tick();
    end
    idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    init_calib_complete = 1'b1;
    cmp_valid = 1'b1;
    cmp_error = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if (state_o !== 2'd0) begin
      n_bad++; $display("FAIL reset_state: got=%0d want=0", state_o);
    end
    n_cmp++;
    if (init_calib_complete_d !== 1'b0) begin
      n_bad++; $display("FAIL reset_sync: got=%b want=0", init_calib_complete_d);
    end
    n_cmp++;
    if ({error_int1, error_int2, err_count, beat_count} !== '0) begin
      n_bad++; $display("FAIL reset_counts: int1=%b int2=%b err=%0d beat=%0d want all 0",
                        error_int1, error_int2, err_count, beat_count);
    end
    idle();
    init_calib_complete = 1'b0;
  endtask

  task automatic test_calib_settle();
    int n;
    apply_reset();
    init_calib_complete = 1'b1;
    n = 0;
    while (init_calib_complete_d !== 1'b1 && n < 3) begin
      tick();
      n++;
    end
    n_cmp++;
    if (init_calib_complete_d !== 1'b1) begin
      n_bad++; $display("FAIL sync_rise: got=%b want=1 within 3 cycles", init_calib_complete_d);
    end
    tick();
    n_cmp++;
    if (state_o !== 2'd1) begin
      n_bad++; $display("FAIL settle_entry: got=%0d want=1", state_o);
    end
    repeat (SETTLE - 1) tick();
    n_cmp++;
    if (state_o !== 2'd1) begin
      n_bad++; $display("FAIL settle_len_early: got=%0d want=1", state_o);
    end
    tick();
    n_cmp++;
    if (state_o !== 2'd2) begin
      n_bad++; $display("FAIL settle_len: got=%0d want=2", state_o);
    end
  endtask

  task automatic test_settle_ignore();
    int n;
    apply_reset();
    init_calib_complete = 1'b1;
    n = 0;
    while (state_o !== 2'd1 && n < 6) begin
      tick();
      n++;
    end
    drive_errors(1);
    n = 0;
    while (state_o !== 2'd2 && n < SETTLE + 4) begin
      tick();
      n++;
    end
    n_cmp++;
    if (state_o !== 2'd2 || err_count !== 16'd0 || beat_count !== 32'd0 || error_int1 !== 1'b0) begin
      n_bad++; $display("FAIL settle_ignore: state=%0d err=%0d beat=%0d int1=%b want 2/0/0/0",
                        state_o, err_count, beat_count, error_int1);
    end
    // three clean beats, then one error
    cmp_valid = 1'b1;
    cmp_error = 1'b0;
    repeat (3) tick();
    cmp_error = 1'b1;
    n_cmp++;
    if (error_int1 !== 1'b0) begin
      n_bad++; $display("FAIL int1_early: got=%b want=0", error_int1);
    end
    tick();
    idle();
    n_cmp++;
    if (err_count !== 16'd1 || error_int1 !== 1'b1 || error_int2 !== 1'b0) begin
      n_bad++; $display("FAIL run_error: err=%0d int1=%b int2=%b want 1/1/0",
                        err_count, error_int1, error_int2);
    end
    n_cmp++;
    if (beat_count !== 32'd4) begin
      n_bad++; $display("FAIL run_beats: got=%0d want=4", beat_count);
    end
`ifdef DDR_MON_ERR_LOG_EN
    n_cmp++;
    if (first_err_beat !== 32'd3) begin
      n_bad++; $display("FAIL first_err_beat: got=%0d want=3", first_err_beat);
    end
`endif
  endtask

  task automatic test_random_scoreboard();
    logic [31:0] eb, gb;
    logic [15:0] ee, ge;
    logic        r_err;
    int          errs_left;
    bring_up();
    eb = 32'd0;
    ee = 16'd0;
    errs_left = THRESH - 1;
    for (int i = 0; i < 300; i++) begin
      cmp_valid = 1'($urandom_range(0, 1));
      r_err     = 1'($urandom_range(0, 1));
      if (cmp_valid && r_err) begin
        if (errs_left > 0 && $urandom_range(0, 9) == 0) errs_left--;
        else r_err = 1'b0;
      end
      cmp_error = r_err;
      if (cmp_valid) eb = eb + 1;
      if (cmp_valid && r_err) ee = ee + 1;
      exp_beat_q.push_back(eb);
      exp_err_q.push_back(ee);
      tick();
      gb = exp_beat_q.pop_front();
      ge = exp_err_q.pop_front();
      n_cmp++;
      if (beat_count !== gb) begin
        n_bad++; $display("FAIL sb_beat[%0d]: got=%0d want=%0d", i, beat_count, gb);
      end
      n_cmp++;
      if (err_count !== ge) begin
        n_bad++; $display("FAIL sb_err[%0d]: got=%0d want=%0d", i, err_count, ge);
      end
    end
    idle();
    n_cmp++;
    if (error_int1 !== (ee != 0) || error_int2 !== 1'b0 || state_o !== 2'd2) begin
      n_bad++; $display("FAIL sb_flags: int1=%b int2=%b state=%0d want %b/0/2",
                        error_int1, error_int2, state_o, (ee != 0));
    end
  endtask

  task automatic test_burst();
    // 8 back-to-back errors in one window
    bring_up();
    drive_errors(THRESH - 1);
    n_cmp++;
    if (error_int2 !== 1'b0 || state_o !== 2'd2) begin
      n_bad++; $display("FAIL burst_7: int2=%b state=%0d want 0/2", error_int2, state_o);
    end
    drive_errors(1);
    n_cmp++;
    if (error_int2 !== 1'b1 || state_o !== 2'd3 || err_count !== 16'd8) begin
      n_bad++; $display("FAIL burst_8: int2=%b state=%0d err=%0d want 1/3/8",
                        error_int2, state_o, err_count);
    end
    // FAULT keeps counting with flags held
    drive_errors(2);
    n_cmp++;
    if (err_count !== 16'd10 || beat_count !== 32'd10 || state_o !== 2'd3 ||
        error_int1 !== 1'b1 || error_int2 !== 1'b1) begin
      n_bad++; $display("FAIL fault_count: err=%0d beat=%0d state=%0d int1=%b int2=%b want 10/10/3/1/1",
                        err_count, beat_count, state_o, error_int1, error_int2);
    end

    // 7 errors per window for 4 windows, clustered around each boundary
    bring_up();
    for (int i = 0; i < 4 * WIN; i++) begin
      int off;
      off = i % WIN;
      cmp_valid = 1'b1;
      cmp_error = (off <= 2 || off >= WIN - 4);
      tick();
    end
    idle();
    n_cmp++;
    if (error_int2 !== 1'b0 || state_o !== 2'd2 || err_count !== 16'd28 || beat_count !== 32'd256) begin
      n_bad++; $display("FAIL burst_7x4: int2=%b state=%0d err=%0d beat=%0d want 0/2/28/256",
                        error_int2, state_o, err_count, beat_count);
    end

    // 7 at the end of window 0, then 8 from the boundary cycle of window 1
    bring_up();
    for (int i = 0; i < WIN + 8; i++) begin
      cmp_valid = 1'b1;
      cmp_error = (i >= WIN - 7);
      tick();
      if (i == WIN + 6) begin
        n_cmp++;
        if (error_int2 !== 1'b0 || state_o !== 2'd2) begin
          n_bad++; $display("FAIL boundary_new_window: int2=%b state=%0d want 0/2", error_int2, state_o);
        end
      end
    end
    idle();
    n_cmp++;
    if (error_int2 !== 1'b1 || state_o !== 2'd3) begin
      n_bad++; $display("FAIL boundary_burst: int2=%b state=%0d want 1/3", error_int2, state_o);
    end
  endtask

  task automatic test_saturation();
    bring_up();
    cmp_valid = 1'b1;
    cmp_error = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 65533) begin
        n_cmp++;
        if (err_count !== 16'hFFFE) begin
          n_bad++; $display("FAIL sat_pre: got=%h want=fffe", err_count);
        end
      end
    end
    idle();
    n_cmp++;
    if (err_count !== 16'hFFFF || beat_count !== 32'd70000 || state_o !== 2'd3) begin
      n_bad++; $display("FAIL sat_hold: err=%h beat=%0d state=%0d want ffff/70000/3",
                        err_count, beat_count, state_o);
    end
    // preload beat counter just below wrap
    force dut.beat_q = 32'hFFFF_FFFF;
    #1;
    release dut.beat_q;
    cmp_valid = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (beat_count !== 32'd0 || err_count !== 16'hFFFF) begin
      n_bad++; $display("FAIL beat_wrap: beat=%h err=%h want 0/ffff", beat_count, err_count);
    end
  endtask

  task automatic test_clear_fault();
    bring_up();
    drive_errors(THRESH);
    n_cmp++;
    if (state_o !== 2'd3) begin
      n_bad++; $display("FAIL clear_pre: state=%0d want=3", state_o);
    end
    clear_i   = 1'b1;
    cmp_valid = 1'b1;
    cmp_error = 1'b1;
    tick();
    idle();
    n_cmp++;
    if ({error_int1, error_int2, err_count, beat_count} !== '0) begin
      n_bad++; $display("FAIL clear_zero: int1=%b int2=%b err=%0d beat=%0d want all 0",
                        error_int1, error_int2, err_count, beat_count);
    end
    n_cmp++;
    if (state_o !== 2'd2) begin
      n_bad++; $display("FAIL clear_state: got=%0d want=2", state_o);
    end
`ifdef DDR_MON_ERR_LOG_EN
    n_cmp++;
    if (first_err_beat !== 32'd0) begin
      n_bad++; $display("FAIL clear_first_err: got=%0d want=0", first_err_beat);
    end
`endif
    drive_errors(THRESH - 1);
    n_cmp++;
    if (err_count !== 16'd7 || error_int1 !== 1'b1 || error_int2 !== 1'b0 || state_o !== 2'd2) begin
      n_bad++; $display("FAIL after_clear: err=%0d int1=%b int2=%b state=%0d want 7/1/0/2",
                        err_count, error_int1, error_int2, state_o);
    end
  endtask

  task automatic test_cal_drop_and_reset();
    int n;
    bring_up();
    cmp_valid = 1'b1;
    cmp_error = 1'b1;
    tick();
    cmp_error = 1'b0;
    tick();
    cmp_error = 1'b1;
    tick();
    idle();
    init_calib_complete = 1'b0;
    n = 0;
    while (state_o !== 2'd0 && n < 5) begin
      tick();
      n++;
    end
    n_cmp++;
    if (state_o !== 2'd0) begin
      n_bad++; $display("FAIL cal_drop_state: got=%0d want=0", state_o);
    end
    n_cmp++;
    if (err_count !== 16'd2 || beat_count !== 32'd3 || error_int1 !== 1'b1) begin
      n_bad++; $display("FAIL cal_drop_retain: err=%0d beat=%0d int1=%b want 2/3/1",
                        err_count, beat_count, error_int1);
    end
    drive_errors(1);
    n_cmp++;
    if (err_count !== 16'd2 || beat_count !== 32'd3) begin
      n_bad++; $display("FAIL wait_cal_ignore: err=%0d beat=%0d want 2/3", err_count, beat_count);
    end

    // asynchronous reset in the middle of a clock period while running
    bring_up();
    drive_errors(3);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({init_calib_complete_d, error_int1, error_int2, err_count, beat_count, state_o} !== '0) begin
      n_bad++; $display("FAIL async_reset: cal_d=%b int1=%b int2=%b err=%0d beat=%0d state=%0d want all 0",
                        init_calib_complete_d, error_int1, error_int2, err_count, beat_count, state_o);
    end
    tick();
    rst_i = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_calib_settle();
    test_settle_ignore();
    test_random_scoreboard();
    test_burst();
    test_saturation();
    test_clear_fault();
    test_cal_drop_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr_test_monitor.md
DDR_TEST_MONITOR -- requirements
Module: ddr_test_monitor

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1024: cycles after calibration during which compare results are ignored.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 4096: length of the burst-error window.
REQ-003 SHALL have parameter BURST_THRESH, default 8: number of errors within one window that raises error_int2.
REQ-004 SHALL have port clk_i, input, 1: single clock (memory_clk domain). One clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst_i, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port init_calib_complete, input, 1: raw DDR calibration done; asynchronous to clk_i.
REQ-007 SHALL have port cmp_valid, input, 1: the checker compared one read beat this cycle.
REQ-008 SHALL have port cmp_error, input, 1: the compared beat mismatched; qualified by cmp_valid.
REQ-009 SHALL have port clear_i, input, 1: synchronous clear of sticky flags and counters.
REQ-010 SHALL have port init_calib_complete_d, output, 1: synchronized calibration done, fed to the analyzer probe.
REQ-011 SHALL have port error_int1, output, 1: sticky flag, any error.
REQ-012 SHALL have port error_int2, output, 1: sticky flag, burst threshold reached.
REQ-013 SHALL have port err_count, output, 16: saturating error count.
REQ-014 SHALL have port beat_count, output, 32: wrapping count of compared beats.
REQ-015 SHALL have port state_o, output, 2: current FSM state.

Function
REQ-016 SHALL synchronize init_calib_complete through 2 flops; init_calib_complete_d rises 2-3 cycles after the input rises.
REQ-017 SHALL implement FSM states: WAIT_CAL=0, SETTLE=1, RUN=2, FAULT=3.
REQ-018 WAIT_CAL -> SETTLE SHALL occur when init_calib_complete_d=1; SETTLE loads a down-counter with SETTLE_CYCLES-1.
REQ-019 SETTLE -> RUN SHALL occur on the cycle the settle counter reaches 0; cmp_* SHALL be ignored in WAIT_CAL and SETTLE.
REQ-020 In RUN, cmp_valid=1 SHALL increment beat_count, wrapping from 0xFFFFFFFF to 0.
REQ-021 In RUN, cmp_valid&cmp_error SHALL increment err_count, saturating at 0xFFFF, and set error_int1 on the next edge.
REQ-022 SHALL keep a window counter in RUN that restarts every WINDOW_CYCLES cycles, together with a per-window error counter that resets at each window boundary.
REQ-023 When the per-window error count reaches BURST_THRESH, error_int2 SHALL be set and the FSM SHALL move RUN -> FAULT.
REQ-024 An error on the window-boundary cycle SHALL be counted in the new window.
REQ-025 In FAULT, beat_count and err_count SHALL keep counting and the flags SHALL stay set.
REQ-026 If init_calib_complete_d falls in any state, the FSM SHALL go to WAIT_CAL; counters and flags SHALL be retained.
REQ-027 clear_i SHALL zero the flags, counters and window; the FSM goes RUN if in FAULT and keeps its state otherwise.
REQ-028 clear_i SHALL take priority over a simultaneous error, which is dropped.

Reset
REQ-029 rst_i SHALL asynchronously set the FSM to WAIT_CAL and the synchronizer flops, all counters and all outputs to 0.
REQ-030 Deassertion of rst_i SHALL be synchronized externally; no internal reset synchronizer is required.

Configuration
REQ-031 With DDR_MON_ERR_LOG_EN defined, the block SHALL add output first_err_beat[31:0], which latches beat_count on the first RUN error and holds until clear_i or reset.
REQ-032 Without DDR_MON_ERR_LOG_EN, first_err_beat and its logic SHALL be absent.

Structure
REQ-033 Package ddr_test_pkg SHALL hold the state enum, the counter widths (16, 32) and the state encoding constants.
REQ-034 The 2-flop synchronizer SHALL be sub-module sync_2ff, instantiated once.

Verification
REQ-035 Rise init_calib_complete with SETTLE_CYCLES=16 -> init_calib_complete_d=1 within 3 cycles; state_o=RUN 16 cycles after SETTLE entry.
REQ-036 Inject 1 error during SETTLE, then 1 in RUN -> err_count=1 and error_int1=1 the cycle after the RUN error; error_int2=0.
REQ-037 With BURST_THRESH=8 and WINDOW_CYCLES=64, inject 8 errors within one window -> error_int2=1 and state_o=FAULT; 7 errors per window for 4 windows -> error_int2=0.
REQ-038 Inject 70000 errors -> err_count holds 0xFFFF; preload beat_count=0xFFFFFFFF, one valid beat -> beat_count=0.
REQ-039 Assert clear_i in FAULT in the same cycle as an error -> all counters 0, flags 0, state_o=RUN.
REQ-040 Assert rst_i mid-RUN -> all outputs 0 and state WAIT_CAL immediately; drop calibration in RUN -> WAIT_CAL with counts retained.
